sm_muldiv: RTL

- Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the schoolMIPS core.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support, which the single-cycle ALU lacks.
- Sits beside the ALU: the CPU issues an operation with a one-cycle start strobe and stalls on busy before mfhi/mflo or a new mul/div.
- A flush input cancels an in-flight operation when an exception is taken.

---
 rtl/sm_muldiv.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sm_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : sm_muldiv
// Description : Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_CALC    = 2'd1;
    localparam logic [1:0]       c_SIGN    = 2'd2;
    localparam logic [2:0]       c_OP_MTHI = 3'd4;
    localparam logic [2:0]       c_OP_MTLO = 3'd5;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state, w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b, r_hi, r_lo;
    logic               r_isDiv, r_negRes, r_negRem, r_done;

    logic               w_accept, w_isMulDiv, w_divZero, w_launch;
    logic               w_negA, w_negB;
    logic [WIDTH-1:0]   w_magA, w_magB;
    logic [WIDTH:0]     w_mulSum, w_divCand, w_divDiff;
    logic [2*WIDTH-1:0] w_mulNext, w_divNext, w_step, w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem, w_resHi, w_resLo;

    assign w_accept   = start & ~flush & (r_state == c_IDLE);
    assign w_isMulDiv = ~oper[2];
    assign w_divZero  = w_accept & w_isMulDiv & oper[1] & (srcB == '0);
    assign w_launch   = w_accept & w_isMulDiv & ~(oper[1] & (srcB == '0));

    // Odd opcodes (MULT, DIV) are the signed variants.
    assign w_negA = oper[0] & srcA[WIDTH-1];
    assign w_negB = oper[0] & srcB[WIDTH-1];
    assign w_magA = w_negA ? -srcA : srcA;
    assign w_magB = w_negB ? -srcB : srcB;

    // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // Divide: r_acc = {remainder, dividend bits / quotient bits}, shifted left.
    assign w_divCand = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_divDiff = w_divCand - {1'b0, r_b};
    assign w_divNext = w_divDiff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_divDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_step    = r_isDiv ? w_divNext : w_mulNext;

    assign w_prod  = r_negRes ? -r_acc : r_acc;
    assign w_quot  = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem   = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_resHi = r_isDiv ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    assign w_resLo = r_isDiv ? w_quot : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_launch) w_nextState = c_CALC;
                c_CALC:  if (r_cnt == c_LAST) w_nextState = c_SIGN;
                c_SIGN:  w_nextState = c_IDLE;
                default: w_nextState = c_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != c_IDLE);
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_isDiv  <= 1'b0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!flush) begin
                case (r_state)
                    c_IDLE: begin
                        if (w_launch) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_magA};
                            r_b      <= w_magB;
                            r_cnt    <= '0;
                            r_isDiv  <= oper[1];
                            r_negRes <= w_negA ^ w_negB;
                            r_negRem <= w_negA;
                        end else if (w_divZero) begin
                            r_hi   <= srcA;
                            r_lo   <= '1;
                            r_done <= 1'b1;
                        end else if (w_accept && oper == c_OP_MTHI) begin
                            r_hi <= srcA;
                        end else if (w_accept && oper == c_OP_MTLO) begin
                            r_lo <= srcA;
                        end
                    end
                    c_CALC: begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    c_SIGN: begin
                        r_hi   <= w_resHi;
                        r_lo   <= w_resLo;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
